cmp_sel_pipe: RTL
=================

# cmp_sel_pipe

Parametrised, pipelined compare-and-select evaluator for the power-aware synthesis training set. Each transaction compares one key against NCH per-channel reference words and gates the result with two mode-selected feature bits from a data word. The block adds a two-stage registered pipeline with valid/ready backpressure and per-channel saturating hit counters. It is the sequential, width- and channel-scalable successor to the flat two-level compare/select benchmarks.

## Interface
- KEY_W, 5, key and reference width (≥1)
- NCH, 6, number of compare channels (≥1)
- DATA_W, 16, feature data word width (≥2)
- CNT_W, 8, hit counter width per channel (≥1)
- SEL_W, $clog2(DATA_W), feature index width (derived, not overridable)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept the input this cycle
- in_key  in  KEY_W  unsigned key
- in_ref  in  NCH*KEY_W  channel c reference at [c*KEY_W +: KEY_W], unsigned
- in_data  in  DATA_W  feature source word
- in_sel_lo  in  SEL_W  index of the "below" feature bit
- in_sel_hi  in  SEL_W  index of the "above" feature bit
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_hit  out  NCH  per-channel hit bit
- out_eq  out  NCH  per-channel key==ref
- hit_cnt  out  NCH*CNT_W  channel c counter at [c*CNT_W +: CNT_W]
- cnt_clr  in  1  synchronous clear of all counters

## Operation
- Feature select: f_lo = in_data[in_sel_lo] and f_hi = in_data[in_sel_hi]. An index ≥ DATA_W yields 0.
- Per channel: lt = key<ref, gt = key>ref, eq = key==ref.
- hit = (gt & f_hi) | (lt & f_lo). eq forces hit=0.
- Stage 1 (S1) registers lt, gt, eq for every channel, plus f_lo and f_hi.
- Stage 2 (S2) registers out_hit and out_eq.
- Advance rules:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; this path is intentional.
- Input handshake: in_valid & in_ready. Output handshake: out_valid & out_ready.
- While stalled, S1/S2 payloads hold. out_hit and out_eq are stable while out_valid & ~out_ready.
- Counters: on each output handshake, hit_cnt[c] increments for each channel with out_hit[c]=1.
  - Saturates at 2^CNT_W−1 and does not wrap.
- cnt_clr sets all counters to 0. cnt_clr and an increment in the same cycle yield 0 (clear wins).
- cnt_clr does not affect the pipeline.

## Timing
- Reset values: S1/S2 valid=0, out_valid=0, out_hit=0, out_eq=0, hit_cnt=0. in_ready=1 in the first cycle after reset.
- Latency: an input accepted in cycle t appears with out_valid=1 in cycle t+2 when out_ready is held high.
- Throughput: one transaction per cycle under continuous out_ready=1.
- Bubbles collapse. With S2 stalled and S1 empty, one more input is accepted. Two transactions can be buffered in total.
- Both stages full with out_ready=0: in_ready=0.
- Reset mid-operation: all in-flight transactions are discarded and the counters clear. There is no partial output.
- hit_cnt is registered. It reflects a handshake one cycle after that handshake.

## Structure
- Package cmp_sel_pkg holds:
  - the default parameter constants;
  - the S1 payload struct {lt, gt, eq, f_lo, f_hi};
  - a helper function to extract channel c from packed in_ref / hit_cnt.
- Sub-module cmp_sel_lane (parameter KEY_W) computes lt/gt/eq for one channel and is instantiated NCH times via generate.
- Feature select, pipeline registers, handshake logic and counters live in cmp_sel_pipe.

## Test plan
- **Single transaction:** after reset, key=5, ref0=3, ref1=7, ref2=5, data bit2=1, bit9=1, sel_lo=9, sel_hi=2, out_ready=1 -> at t+2: out_hit[0]=1, out_hit[1]=1, out_hit[2]=0, out_eq[2]=1; hit_cnt0=1 and hit_cnt1=1 next cycle.
- **Out-of-range select:** DATA_W=12, sel_hi=15, key>all refs -> out_hit=0 on every channel.
- **Backpressure:** stream 4 transactions with out_ready=0 -> in_ready falls after 2 are accepted; out payload holds unchanged; raising out_ready delivers all 4 in order, with no loss or duplication.
- **Saturation:** CNT_W=3, force channel 0 to hit on 10 handshakes -> hit_cnt0 is 7 and stays 7.
- **Clear vs. increment:** cnt_clr asserted in the same cycle as a hitting handshake -> hit_cnt=0 on the next cycle.
- **Reset mid-stream:** assert rst with both stages full -> next cycle out_valid=0, hit_cnt=0, in_ready=1; no stale result ever appears.

Source files
------------

// File: rtl/cmp_sel_pkg.sv
// rtl/cmp_sel_pkg.sv - shared defaults, stage-1 lane payload and packed-channel accessor
package cmp_sel_pkg;

    localparam int DEF_KEY_W  = 5;
    localparam int DEF_NCH    = 6;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 8;

    // Widest packed channel vector the accessor handles; fields are at most 32 bits.
    localparam int VEC_MAX_W  = 256;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic f_lo;
        logic f_hi;
    } s1_lane_t;

    function automatic logic [31:0] chan_field(input logic [VEC_MAX_W-1:0] vec,
                                               input int c, input int w);
        logic [VEC_MAX_W-1:0] sh;
        logic [31:0]          mask;
        sh   = vec >> (c * w);
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return sh[31:0] & mask;
    endfunction

endpackage

// File: rtl/cmp_sel_pipe_if.sv
// rtl/cmp_sel_pipe_if.sv - transaction input and result output handshake bundle
interface cmp_sel_pipe_if #(
    parameter int KEY_W  = 5,
    parameter int NCH    = 6,
    parameter int DATA_W = 16
);
    localparam int SEL_W = $clog2(DATA_W);

    logic                 in_valid;
    logic                 in_ready;
    logic [KEY_W-1:0]     in_key;
    logic [NCH*KEY_W-1:0] in_ref;
    logic [DATA_W-1:0]    in_data;
    logic [SEL_W-1:0]     in_sel_lo;
    logic [SEL_W-1:0]     in_sel_hi;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH-1:0]       out_hit;
    logic [NCH-1:0]       out_eq;

    modport master (
        output in_valid, in_key, in_ref, in_data, in_sel_lo, in_sel_hi, out_ready,
        input  in_ready, out_valid, out_hit, out_eq
    );

    modport slave (
        input  in_valid, in_key, in_ref, in_data, in_sel_lo, in_sel_hi, out_ready,
        output in_ready, out_valid, out_hit, out_eq
    );
endinterface

// File: rtl/cmp_sel_lane.sv
// rtl/cmp_sel_lane.sv - unsigned magnitude compare of the key against one channel reference
module cmp_sel_lane
    import cmp_sel_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W
) (
    input  logic [KEY_W-1:0] key,
    input  logic [KEY_W-1:0] ref_val,
    output logic             lt,
    output logic             gt,
    output logic             eq
);
    assign lt = key < ref_val;
    assign gt = key > ref_val;
    assign eq = key == ref_val;
endmodule

// File: rtl/cmp_sel_pipe.sv
// rtl/cmp_sel_pipe.sv - two-stage compare/select pipeline with per-channel saturating hit counters
module cmp_sel_pipe
    import cmp_sel_pkg::*;
#(
    parameter int KEY_W  = DEF_KEY_W,
    parameter int NCH    = DEF_NCH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    cmp_sel_pipe_if.slave        bus,
    input  logic                 cnt_clr,
    output logic [NCH*CNT_W-1:0] hit_cnt
);
    localparam int SEL_W = $clog2(DATA_W);
    localparam int DPAD  = 1 << SEL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [VEC_MAX_W-1:0] ref_ext;
    logic [DPAD-1:0]      data_pad;
    logic [NCH-1:0]       lt, gt, eq;
    logic                 f_lo, f_hi;

    s1_lane_t             s1_q [NCH];
    logic                 s1_valid, s2_valid;
    logic                 s1_adv, s2_adv, out_hs;
    logic [NCH-1:0]       s2_hit_d, s2_eq_d, s2_hit_q, s2_eq_q;
    logic [CNT_W-1:0]     cnt_q [NCH];

    // Zero padding up to 2**SEL_W makes out-of-range selects read as 0.
    assign data_pad = DPAD'(bus.in_data);
    assign f_lo     = data_pad[bus.in_sel_lo];
    assign f_hi     = data_pad[bus.in_sel_hi];
    assign ref_ext  = VEC_MAX_W'(bus.in_ref);

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        logic [KEY_W-1:0] ref_c;
        assign ref_c = KEY_W'(chan_field(ref_ext, c, KEY_W));
        cmp_sel_lane #(.KEY_W(KEY_W)) u_lane (
            .key     (bus.in_key),
            .ref_val (ref_c),
            .lt      (lt[c]),
            .gt      (gt[c]),
            .eq      (eq[c])
        );
        assign hit_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
    end

    assign s2_adv       = ~s2_valid | bus.out_ready;
    assign s1_adv       = ~s1_valid | s2_adv;
    assign out_hs       = s2_valid & bus.out_ready;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int c = 0; c < NCH; c++) s1_q[c] <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                for (int c = 0; c < NCH; c++)
                    s1_q[c] <= '{lt: lt[c], gt: gt[c], eq: eq[c], f_lo: f_lo, f_hi: f_hi};
            end
        end
    end

    always_comb begin
        s2_hit_d = '0;
        s2_eq_d  = '0;
        for (int c = 0; c < NCH; c++) begin
            s2_hit_d[c] = ~s1_q[c].eq & ((s1_q[c].gt & s1_q[c].f_hi) | (s1_q[c].lt & s1_q[c].f_lo));
            s2_eq_d[c]  = s1_q[c].eq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_hit_q <= '0;
            s2_eq_q  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_hit_q <= s2_hit_d;
                s2_eq_q  <= s2_eq_d;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_hit   = s2_hit_q;
    assign bus.out_eq    = s2_eq_q;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
        end else if (out_hs) begin
            for (int c = 0; c < NCH; c++)
                if (s2_hit_q[c] && (cnt_q[c] != CNT_MAX)) cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        end
    end

endmodule
